// File: rtl/am29xx_useq_if.sv
// am29xx_useq_if: control, data and status bundle of the microprogram sequencer.
// The tri-state address output y is not in this bundle; it is a separate port of the sequencer.
interface am29xx_useq_if #(parameter int WIDTH = 12);
    logic             cin;
    logic [WIDTH-1:0] ora;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] d;
    logic [1:0]       s;
    logic             fe_n;
    logic             pup;
    logic             re_n;
    logic             za_n;
    logic             oe_n;
    logic             lc_ld;
    logic             lc_dec;
    logic             cout;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             unf;
    logic             lc_zero;
    modport master (
        output cin, ora, r, d, s, fe_n, pup, re_n, za_n, oe_n, lc_ld, lc_dec,
        input  cout, full, empty, ovf, unf, lc_zero
    );
    modport slave (
        input  cin, ora, r, d, s, fe_n, pup, re_n, za_n, oe_n, lc_ld, lc_dec,
        output cout, full, empty, ovf, unf, lc_zero
    );
endinterface

// File: rtl/am29xx_useq.sv
// am29xx_useq: microprogram sequencer with a source mux, an OR-mask, a PC incrementer,
// a return stack and a loop counter.
module am29xx_useq #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             cp,
    input  logic             rst_n,
    am29xx_useq_if.slave     bus,
    output wire  [WIDTH-1:0] y
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
    logic [WIDTH-1:0] r_pc, r_ar, r_lc;
    logic [PW-1:0]    r_cnt;
    logic             r_ovf, r_unf;
    logic [WIDTH-1:0] r_stk [2**PW];
    logic [WIDTH-1:0] w_top, w_src, w_out;
    logic             w_full, w_empty, w_push, w_pop;
    assign w_full  = r_cnt == FULL_CNT;
    assign w_empty = r_cnt == '0;
    assign w_top   = w_empty ? '0 : r_stk[r_cnt - 1'b1];
    assign w_src   = bus.s[1] ? (bus.s[0] ? bus.d : w_top) : (bus.s[0] ? r_ar : r_pc);
    // Output is held at zero throughout reset, not only after the registers clear
    assign w_out   = (rst_n && bus.za_n) ? (w_src | bus.ora) : '0;
    assign w_push  = bus.za_n && !bus.fe_n && bus.pup;
    assign w_pop   = bus.za_n && !bus.fe_n && !bus.pup;
    assign y           = bus.oe_n ? {WIDTH{1'bz}} : w_out;
    assign bus.cout    = (&w_out) & bus.cin;
    assign bus.full    = w_full;
    assign bus.empty   = w_empty;
    assign bus.ovf     = r_ovf;
    assign bus.unf     = r_unf;
    assign bus.lc_zero = r_lc == '0;
    always_ff @(posedge cp)
        if (w_push && !w_full) r_stk[r_cnt] <= r_pc;
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= '0;
            r_ar  <= '0;
            r_lc  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc <= w_out + WIDTH'(bus.cin);
            if (!bus.re_n) r_ar <= bus.r;
            if (!bus.za_n) r_cnt <= '0;
            else if (w_push) begin
                if (w_full) r_ovf <= 1'b1;
                else r_cnt <= r_cnt + 1'b1;
            end else if (w_pop) begin
                if (w_empty) r_unf <= 1'b1;
                else r_cnt <= r_cnt - 1'b1;
            end
            r_lc <= bus.lc_ld ? bus.d : (bus.lc_dec && r_lc != '0) ? r_lc - 1'b1 : r_lc;
        end
    end
endmodule

// File: tb/tb_am29xx_useq.sv
// tb_am29xx_useq: directed vector table plus randomized run against a queue-based sequencer model.
module tb_am29xx_useq;
    localparam int W = 12;
    localparam int D = 4;
    localparam int MASK = (1 << W) - 1;
    logic cp, rst_n;
    wire [W-1:0] y;
    am29xx_useq_if #(.WIDTH(W)) bus ();
    am29xx_useq #(.WIDTH(W), .DEPTH(D)) dut (.cp(cp), .rst_n(rst_n), .bus(bus), .y(y));
    initial begin
        cp = 1'b0;
        forever #5 cp = ~cp;
    end
    typedef struct {
        logic [1:0] s;
        logic [W-1:0] d, r, ora;
        logic cin, fe_n, pup, re_n, za_n, ld, dec;
        logic [W-1:0] ey;
        logic ecout, efull, eempty, eovf, eunf, elz;
    } vec_t;
    int n_chk = 0, n_fail = 0;
    int m_pc, m_ar, m_lc;
    int m_q[$];
    bit m_ovf, m_unf;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic vec_t mk(input int s, d, r, ora, cin, fe_n, pup, re_n, za_n, ld, dec,
                                input int ey, ecout, efull, eempty, eovf, eunf, elz);
        vec_t v;
        v.s = 2'(s); v.d = W'(d); v.r = W'(r); v.ora = W'(ora);
        v.cin = 1'(cin); v.fe_n = 1'(fe_n); v.pup = 1'(pup); v.re_n = 1'(re_n);
        v.za_n = 1'(za_n); v.ld = 1'(ld); v.dec = 1'(dec);
        v.ey = W'(ey); v.ecout = 1'(ecout); v.efull = 1'(efull); v.eempty = 1'(eempty);
        v.eovf = 1'(eovf); v.eunf = 1'(eunf); v.elz = 1'(elz);
        return v;
    endfunction
    task automatic apply(input vec_t v);
        bus.s = v.s; bus.d = v.d; bus.r = v.r; bus.ora = v.ora; bus.cin = v.cin;
        bus.fe_n = v.fe_n; bus.pup = v.pup; bus.re_n = v.re_n; bus.za_n = v.za_n;
        bus.lc_ld = v.ld; bus.lc_dec = v.dec; bus.oe_n = 1'b0;
    endtask
    task automatic model_reset();
        m_pc = 0; m_ar = 0; m_lc = 0; m_q.delete(); m_ovf = 0; m_unf = 0;
    endtask
    function automatic int model_out();
        int src;
        if (bus.s == 2'd0) src = m_pc;
        else if (bus.s == 2'd1) src = m_ar;
        else if (bus.s == 2'd2) src = (m_q.size() > 0) ? m_q[$] : 0;
        else src = int'(bus.d);
        return (rst_n && bus.za_n) ? ((src | int'(bus.ora)) & MASK) : 0;
    endfunction
    task automatic model_check();
        int o;
        o = model_out();
        if (!bus.oe_n) chk("model_y", 32'(y), 32'(o));
        chk("model_cout", 32'(bus.cout), 32'(o == MASK && bus.cin));
        chk("model_full", 32'(bus.full), 32'(m_q.size() == D));
        chk("model_empty", 32'(bus.empty), 32'(m_q.size() == 0));
        chk("model_ovf", 32'(bus.ovf), 32'(m_ovf));
        chk("model_unf", 32'(bus.unf), 32'(m_unf));
        chk("model_lc_zero", 32'(bus.lc_zero), 32'(m_lc == 0));
    endtask
    task automatic model_update();
        int o, old_pc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        o = model_out();
        old_pc = m_pc;
        m_pc = (o + int'(bus.cin)) & MASK;
        if (!bus.re_n) m_ar = int'(bus.r);
        if (!bus.za_n) m_q.delete();
        else if (!bus.fe_n && bus.pup) begin
            if (m_q.size() < D) m_q.push_back(old_pc);
            else m_ovf = 1;
        end else if (!bus.fe_n) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else m_unf = 1;
        end
        if (bus.lc_ld) m_lc = int'(bus.d);
        else if (bus.lc_dec && m_lc != 0) m_lc = m_lc - 1;
    endtask
    task automatic cycle(input bit tab, input vec_t v, input int idx);
        @(negedge cp);
        model_check();
        if (tab) begin
            chk($sformatf("v%0d_y", idx), 32'(y), 32'(v.ey));
            chk($sformatf("v%0d_cout", idx), 32'(bus.cout), 32'(v.ecout));
            chk($sformatf("v%0d_full", idx), 32'(bus.full), 32'(v.efull));
            chk($sformatf("v%0d_empty", idx), 32'(bus.empty), 32'(v.eempty));
            chk($sformatf("v%0d_ovf", idx), 32'(bus.ovf), 32'(v.eovf));
            chk($sformatf("v%0d_unf", idx), 32'(bus.unf), 32'(v.eunf));
            chk($sformatf("v%0d_lc_zero", idx), 32'(bus.lc_zero), 32'(v.elz));
        end
        model_update();
        @(posedge cp);
        #1;
    endtask
    vec_t tab[$];
    vec_t idle;
    initial begin
        idle = mk(0,0,0,0,0,1,0,1,1,0,0, 0,0,0,0,0,0,0);
        // stack fill: pushes of pc 1..5, then pops returning 4,3,2,1 and an underflow
        tab.push_back(mk(0,0,0,0,1,1,0,1,1,0,0, 0,0,0,1,0,0,1));
        tab.push_back(mk(0,0,0,0,1,0,1,1,1,0,0, 1,0,0,1,0,0,1));
        tab.push_back(mk(0,0,0,0,1,0,1,1,1,0,0, 2,0,0,0,0,0,1));
        tab.push_back(mk(0,0,0,0,1,0,1,1,1,0,0, 3,0,0,0,0,0,1));
        tab.push_back(mk(0,0,0,0,1,0,1,1,1,0,0, 4,0,0,0,0,0,1));
        tab.push_back(mk(0,0,0,0,1,0,1,1,1,0,0, 5,0,1,0,0,0,1));
        tab.push_back(mk(2,0,0,0,0,0,0,1,1,0,0, 4,0,1,0,1,0,1));
        tab.push_back(mk(2,0,0,0,0,0,0,1,1,0,0, 3,0,0,0,1,0,1));
        tab.push_back(mk(2,0,0,0,0,0,0,1,1,0,0, 2,0,0,0,1,0,1));
        tab.push_back(mk(2,0,0,0,0,0,0,1,1,0,0, 1,0,0,0,1,0,1));
        tab.push_back(mk(2,0,0,0,0,0,0,1,1,0,0, 0,0,0,1,1,0,1));
        // zero address with push and OR-mask
        tab.push_back(mk(0,0,0,0,0,0,1,1,1,0,0, 0,0,0,1,1,1,1));
        tab.push_back(mk(3,'h123,0,'h00F,0,0,1,1,0,0,0, 0,0,0,0,1,1,1));
        tab.push_back(mk(0,0,0,0,0,1,0,1,1,0,0, 0,0,0,1,1,1,1));
        // AR load and OR-mask, then incrementer wrap
        tab.push_back(mk(0,0,'h120,0,0,1,0,0,1,0,0, 0,0,0,1,1,1,1));
        tab.push_back(mk(1,0,0,'h00A,0,1,0,1,1,0,0, 'h12A,0,0,1,1,1,1));
        tab.push_back(mk(3,'hFFF,0,0,1,1,0,1,1,0,0, 'hFFF,1,0,1,1,1,1));
        tab.push_back(mk(0,0,0,0,0,1,0,1,1,0,0, 0,0,0,1,1,1,1));
        // loop counter: load 3, dec x4, then load+dec of 5 counted down
        tab.push_back(mk(0,3,0,0,0,1,0,1,1,1,0, 0,0,0,1,1,1,1));
        tab.push_back(mk(0,0,0,0,0,1,0,1,1,0,1, 0,0,0,1,1,1,0));
        tab.push_back(mk(0,0,0,0,0,1,0,1,1,0,1, 0,0,0,1,1,1,0));
        tab.push_back(mk(0,0,0,0,0,1,0,1,1,0,1, 0,0,0,1,1,1,0));
        tab.push_back(mk(0,0,0,0,0,1,0,1,1,0,1, 0,0,0,1,1,1,1));
        tab.push_back(mk(0,5,0,0,0,1,0,1,1,1,1, 0,0,0,1,1,1,1));
        for (int i = 0; i < 5; i++) tab.push_back(mk(0,0,0,0,0,1,0,1,1,0,1, 0,0,0,1,1,1,0));
        tab.push_back(mk(0,0,0,0,0,1,0,1,1,0,0, 0,0,0,1,1,1,1));
        rst_n = 1'b0;
        apply(idle);
        bus.cin = 1'b1;
        model_reset();
        repeat (2) @(posedge cp);
        @(negedge cp);
        chk("rst_y", 32'(y), 0);
        chk("rst_cout", 32'(bus.cout), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_lc_zero", 32'(bus.lc_zero), 1);
        chk("rst_ovf", 32'(bus.ovf), 0);
        chk("rst_unf", 32'(bus.unf), 0);
        @(posedge cp);
        #1;
        rst_n = 1'b1;
        foreach (tab[i]) begin
            apply(tab[i]);
            cycle(1'b1, tab[i], i);
        end
        apply(mk(1,0,0,'h00A,0,1,0,1,1,0,0, 0,0,0,0,0,0,0));
        bus.oe_n = 1'b1;
        #2;
        chk("y_hiz", 32'(y === 12'hzzz || y === 12'h000), 1);
        cycle(1'b0, idle, 0);
        // async reset asserted mid-cycle during a push, with ovf set and pc nonzero
        apply(mk(3,'h055,0,0,0,1,0,1,1,0,0, 0,0,0,0,0,0,0));
        cycle(1'b0, idle, 0);
        apply(mk(0,0,0,0,0,0,1,1,1,0,0, 0,0,0,0,0,0,0));
        #2;
        chk("pre_rst_y", 32'(y), 'h055);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_y", 32'(y), 0);
        chk("midrst_empty", 32'(bus.empty), 1);
        chk("midrst_ovf", 32'(bus.ovf), 0);
        @(posedge cp);
        #1;
        rst_n = 1'b1;
        apply(idle);
        @(negedge cp);
        chk("postrst_pc", 32'(y), 0);
        chk("postrst_empty", 32'(bus.empty), 1);
        @(posedge cp);
        #1;
        model_reset();
        for (int i = 0; i < 600; i++) begin
            bus.s = 2'($urandom_range(0, 3));
            bus.d = ($urandom % 4 == 0) ? W'($urandom_range(0, 6)) : ($urandom % 8 == 0) ? W'(MASK) : W'($urandom);
            bus.r = W'($urandom);
            bus.ora = ($urandom % 4 == 0) ? W'($urandom) : '0;
            bus.cin = 1'($urandom);
            bus.fe_n = ($urandom % 3 == 0);
            bus.pup = 1'($urandom);
            bus.re_n = 1'($urandom);
            bus.za_n = ($urandom % 16 != 0);
            bus.oe_n = ($urandom % 8 == 0);
            bus.lc_ld = ($urandom % 8 == 0);
            bus.lc_dec = 1'($urandom);
            if ($urandom % 50 == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else rst_n = 1'b1;
            cycle(1'b0, idle, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
